svd_stream_host: RTL and testbench

- Host-side companion to the 4x4 complex bidiagonalization core. It is the other end of the core's serial sample interface.
- It buffers a 4x4 complex matrix written by the host and streams it into the core as one contiguous 16-sample burst.
- It then collects the core's 16-sample result burst into a result buffer that the host can read by address.
- It reports busy, done and error status.

---
 rtl/svd_stream_host.sv | 155 +++++++++++++++
 tb/tb_svd_stream_host.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svd_stream_host.sv
// rtl/svd_stream_host.sv - host-side buffer and serial streamer for the 4x4 complex bidiagonalization core
// Streams a buffered 16-sample matrix to the core, then collects the 16-sample result burst.
module svd_stream_host #(
  parameter int BIT_NUM      = 18,
  parameter int CHANNEL_SIZE = 16,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [BIT_NUM-1:0] wr_r,
  input  logic [BIT_NUM-1:0] wr_i,
  input  logic               start,
  input  logic [3:0]         rd_addr,
  output logic [BIT_NUM-1:0] rd_r,
  output logic [BIT_NUM-1:0] rd_i,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic               core_valid_o,
  output logic [BIT_NUM-1:0] core_R_o,
  output logic [BIT_NUM-1:0] core_I_o,
  input  logic               core_valid_i,
  input  logic [BIT_NUM-1:0] core_R_i,
  input  logic [BIT_NUM-1:0] core_I_i
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_COLLECT, S_DONE} state_t;

  state_t             r_state;
  logic [BIT_NUM-1:0] r_src_r [CHANNEL_SIZE];
  logic [BIT_NUM-1:0] r_src_i [CHANNEL_SIZE];
  logic [BIT_NUM-1:0] r_res_r [CHANNEL_SIZE];
  logic [BIT_NUM-1:0] r_res_i [CHANNEL_SIZE];
  logic [3:0]         r_cnt;
  logic [3:0]         r_rcv;
  logic [TW-1:0]      r_tcnt;
  logic               w_overrun;

  // Result samples outside WAIT/COLLECT have nowhere to go.
  assign w_overrun = core_valid_i &&
                     (r_state == S_IDLE || r_state == S_SEND || r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNEL_SIZE; k++) begin
        r_src_r[k] <= '0;
        r_src_i[k] <= '0;
      end
    end else if (wr_en && !busy) begin
      r_src_r[wr_addr] <= wr_r;
      r_src_i[wr_addr] <= wr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= '0;
      rd_i <= '0;
    end else begin
      rd_r <= r_res_r[rd_addr];
      rd_i <= r_res_i[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rcv        <= '0;
      r_tcnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 2'd0;
      core_valid_o <= 1'b0;
      core_R_o     <= '0;
      core_I_o     <= '0;
      for (int k = 0; k < CHANNEL_SIZE; k++) begin
        r_res_r[k] <= '0;
        r_res_i[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Sample 0 goes out on the same edge that accepts start.
            r_state      <= S_SEND;
            busy         <= 1'b1;
            err          <= 2'd0;
            r_cnt        <= '0;
            core_valid_o <= 1'b1;
            core_R_o     <= r_src_r[0];
            core_I_o     <= r_src_i[0];
          end
        end
        S_SEND: begin
          if (r_cnt == 4'(CHANNEL_SIZE - 1)) begin
            core_valid_o <= 1'b0;
            core_R_o     <= '0;
            core_I_o     <= '0;
            r_tcnt       <= '0;
            r_state      <= S_WAIT;
          end else begin
            r_cnt    <= r_cnt + 4'd1;
            core_R_o <= r_src_r[r_cnt + 4'd1];
            core_I_o <= r_src_i[r_cnt + 4'd1];
          end
        end
        S_WAIT: begin
          if (core_valid_i) begin
            r_res_r[0] <= core_R_i;
            r_res_i[0] <= core_I_i;
            r_rcv      <= 4'd1;
            r_state    <= S_COLLECT;
          end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
            err     <= 2'd1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_COLLECT: begin
          if (core_valid_i) begin
            r_res_r[r_rcv] <= core_R_i;
            r_res_i[r_rcv] <= core_I_i;
            if (r_rcv == 4'(CHANNEL_SIZE - 1)) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rcv <= r_rcv + 4'd1;
            end
          end else begin
            err     <= 2'd2;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_overrun) begin
        err <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_svd_stream_host.sv
// tb/tb_svd_stream_host.sv - randomized self-checking bench for svd_stream_host
// A per-cycle expectation timeline is derived from transaction-level rules and compared every cycle.
module tb_svd_stream_host;
  localparam int BN   = 18;
  localparam int NS   = 16;
  localparam int TO   = 64;
  localparam int MAXC = 6000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [BN-1:0] wr_r = '0, wr_i = '0;
  logic          start = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic [BN-1:0] rd_r, rd_i;
  logic          busy, done;
  logic [1:0]    err;
  logic          core_valid_o;
  logic [BN-1:0] core_R_o, core_I_o;
  logic          core_valid_i = 1'b0;
  logic [BN-1:0] core_R_i = '0, core_I_i = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_send_cyc = 0;
  int last_done_cyc = 0;

  bit          e_valid [MAXC];
  bit [BN-1:0] e_r [MAXC];
  bit [BN-1:0] e_i [MAXC];
  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  bit [1:0]    e_err [MAXC];
  bit [BN-1:0] src_r [NS], src_i [NS], res_r [NS], res_i [NS];
  logic [BN-1:0] lb_r [$];
  logic [BN-1:0] lb_i [$];

  svd_stream_host #(.BIT_NUM(BN), .CHANNEL_SIZE(NS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_r(wr_r), .wr_i(wr_i),
    .start(start), .rd_addr(rd_addr), .rd_r(rd_r), .rd_i(rd_i),
    .busy(busy), .done(done), .err(err),
    .core_valid_o(core_valid_o), .core_R_o(core_R_o), .core_I_o(core_I_o),
    .core_valid_i(core_valid_i), .core_R_i(core_R_i), .core_I_i(core_I_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic void set_busy(input int from, input int upto, input bit v);
    for (int c = from; c <= upto && c < MAXC; c++) e_busy[c] = v;
  endfunction

  function automatic void set_err_from(input int from, input bit [1:0] v);
    for (int c = from; c < MAXC; c++) e_err[c] = v;
  endfunction

  function automatic void zero_from(input int from);
    for (int c = from; c < MAXC; c++) begin
      e_valid[c] = 0; e_r[c] = '0; e_i[c] = '0;
      e_busy[c] = 0; e_done[c] = 0; e_err[c] = 2'd0;
    end
  endfunction

  // Every-cycle comparison of the registered outputs against the timeline.
  initial begin
    @(negedge clk);
    @(negedge clk);
    forever begin
      @(negedge clk);
      if (cyc < MAXC) begin
        chk("core_valid_o", core_valid_o, e_valid[cyc]);
        chk("core_R_o", core_R_o, e_r[cyc]);
        chk("core_I_o", core_I_o, e_i[cyc]);
        chk("busy", busy, e_busy[cyc]);
        chk("done", done, e_done[cyc]);
        chk("err", err, e_err[cyc]);
      end
    end
  end

  always @(negedge clk) begin
    if (core_valid_o === 1'b1) begin
      lb_r.push_back(core_R_o);
      lb_i.push_back(core_I_o);
      last_send_cyc = cyc;
    end
    if (done === 1'b1) last_done_cyc = cyc;
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  task automatic load_src(input bit pattern);
    for (int k = 0; k < NS; k++) begin
      step();
      wr_en   = 1'b1;
      wr_addr = 4'(k);
      wr_r    = pattern ? BN'(k) : BN'($urandom());
      wr_i    = pattern ? BN'(-k) : BN'($urandom());
      src_r[k] = wr_r;
      src_i[k] = wr_i;
    end
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_all(input string tag);
    step();
    rd_addr = 4'd0;
    for (int k = 0; k < NS; k++) begin
      step();
      chk($sformatf("%s_rd_r[%0d]", tag, k), rd_r, res_r[k]);
      chk($sformatf("%s_rd_i[%0d]", tag, k), rd_i, res_i[k]);
      rd_addr = 4'(k + 1);
    end
  endtask

  task automatic read_one(input int a, output logic [BN-1:0] vr, output logic [BN-1:0] vi);
    step();
    rd_addr = 4'(a);
    step();
    vr = rd_r;
    vi = rd_i;
  endtask

  // nret=0 means the core never answers; first result arrives delay cycles after the last sent sample.
  task automatic run_txn(input int delay, input int nret, input bit loop, input bit disturb);
    int s, f, d, j;
    bit [BN-1:0] rr [NS];
    bit [BN-1:0] ri [NS];
    bit [BN-1:0] old0_r, old0_i;
    lb_r.delete();
    lb_i.delete();
    old0_r = res_r[0];
    old0_i = res_i[0];
    f = 0;
    step();
    rd_addr = 4'd0;
    s = cyc;
    start = 1'b1;
    for (int k = 0; k < NS; k++) begin
      e_valid[s + 1 + k] = 1;
      e_r[s + 1 + k] = src_r[k];
      e_i[s + 1 + k] = src_i[k];
    end
    if (nret == 0) begin
      d = s + NS + TO + 1;
    end else begin
      f = s + NS + delay;
      d = (nret == NS) ? f + NS : f + nret + 1;
    end
    set_busy(s + 1, d, 1);
    e_done[d] = 1;
    set_err_from(s + 1, 2'd0);
    if (nret == 0) set_err_from(d, 2'd1);
    else if (nret < NS) set_err_from(d, 2'd2);
    while (cyc < d + 2) begin
      step();
      start = 1'b0;
      wr_en = 1'b0;
      core_valid_i = 1'b0;
      core_R_i = '0;
      core_I_i = '0;
      if (disturb && cyc == s + 3) begin
        wr_en = 1'b1; wr_addr = 4'd5; wr_r = 18'h1FFFF; wr_i = 18'h1FFFF;
      end
      if (disturb && cyc == s + 5) start = 1'b1;
      if (nret > 0 && cyc >= f && cyc < f + nret) begin
        j = cyc - f;
        core_valid_i = 1'b1;
        if (loop) begin
          core_R_i = (j < lb_r.size()) ? lb_r[j] : '0;
          core_I_i = (j < lb_i.size()) ? lb_i[j] : '0;
          rr[j] = src_r[j];
          ri[j] = src_i[j];
        end else begin
          core_R_i = BN'($urandom());
          core_I_i = BN'($urandom());
          rr[j] = core_R_i;
          ri[j] = core_I_i;
        end
      end
      if (nret > 0 && cyc == f + 1) begin
        #1;
        chk("rd_same_cycle_old_r", rd_r, old0_r);
        chk("rd_same_cycle_old_i", rd_i, old0_i);
      end
      if (nret > 0 && cyc == f + 2) begin
        #1;
        chk("rd_after_write_r", rd_r, rr[0]);
        chk("rd_after_write_i", rd_i, ri[0]);
      end
    end
    for (int k = 0; k < nret; k++) begin
      res_r[k] = rr[k];
      res_i[k] = ri[k];
    end
  endtask

  task automatic overrun_idle();
    step();
    core_valid_i = 1'b1;
    core_R_i = BN'($urandom());
    core_I_i = BN'($urandom());
    set_err_from(cyc + 1, 2'd3);
    step();
    core_valid_i = 1'b0;
    core_R_i = '0;
    core_I_i = '0;
  endtask

  initial begin
    logic [BN-1:0] vr, vi;
    int s, n;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_r", rd_r, 0);
    chk("rst_core_valid_o", core_valid_o, 0);
    step();
    rst_n = 1'b1;

    // Ramp pattern looped back 10 cycles after the send burst.
    load_src(1'b1);
    run_txn(10, NS, 1'b1, 1'b0);
    read_all("loop");
    read_one(3, vr, vi);
    chk("loop_res3_r", vr, 32'h3);
    chk("loop_res3_i", vi, 32'h3FFFD);
    chk("loop_err", err, 0);

    // No answer: 64 waiting cycles after the last sent sample, then done.
    run_txn(0, 0, 1'b0, 1'b0);
    chk("timeout_err", err, 1);
    chk("timeout_latency", 32'(last_done_cyc - last_send_cyc), 32'd65);
    chk("timeout_busy", busy, 0);

    run_txn(5, 9, 1'b0, 1'b0);
    chk("short_err", err, 2);
    read_all("short");
    read_one(12, vr, vi);
    chk("short_res12_r", vr, 32'hC);
    chk("short_res12_i", vi, 32'h3FFF4);

    overrun_idle();
    chk("overrun_err", err, 3);
    read_all("overrun");

    // Ignored write/start during SEND, first result on the last accepted cycle of the wait window.
    run_txn(TO, NS, 1'b0, 1'b1);
    chk("restart_err_cleared", err, 0);

    // Asynchronous reset while sample 7 is on the core port.
    load_src(1'b0);
    step();
    s = cyc;
    start = 1'b1;
    for (int k = 0; k < NS; k++) begin
      e_valid[s + 1 + k] = 1;
      e_r[s + 1 + k] = src_r[k];
      e_i[s + 1 + k] = src_i[k];
    end
    set_busy(s + 1, s + 200, 1);
    set_err_from(s + 1, 2'd0);
    step();
    start = 1'b0;
    while (cyc < s + 8) step();
    rst_n = 1'b0;
    zero_from(cyc);
    #1;
    chk("rst_mid_valid", core_valid_o, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < NS; k++) begin
      src_r[k] = '0; src_i[k] = '0; res_r[k] = '0; res_i[k] = '0;
    end
    read_all("post_rst");
    load_src(1'b0);
    run_txn(int'($urandom_range(1, TO)), NS, 1'b1, 1'b0);
    read_all("post_rst_txn");

    for (int t = 0; t < 10 && cyc < MAXC - 400; t++) begin
      if ($urandom_range(0, 1) == 1) load_src(1'b0);
      if ($urandom_range(0, 3) == 0) overrun_idle();
      n = int'($urandom_range(0, 9));
      if (n <= 5) n = NS;
      else if (n <= 8) n = int'($urandom_range(1, NS - 1));
      else n = 0;
      run_txn(int'($urandom_range(1, TO)), n, 1'($urandom_range(0, 1)), 1'b0);
      read_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
